frv_dispatch_nfwd: RTL and testbench

FRV_DISPATCH_NFWD -- requirements
Module: frv_dispatch_nfwd

---
 rtl/frv_dispatch_nfwd.sv | 219 +++++++++++++++++++++
 tb/tb_frv_dispatch_nfwd.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frv_dispatch_nfwd.sv
// frv_dispatch_nfwd: decode->execute dispatch stage.
// Reads operands from a 32-entry GPR file, with forwarding from NFWD younger pipeline stages.
// Stalls on results that later stages have not produced yet.
// Builds the A/B/C operands and places them in a 1- or 2-entry output buffer.
// Ports:
//   g_clk, g_resetn            clock, synchronous active-low reset
//   s2_*                       decode-side instruction and handshake (s2_p_valid/s2_p_busy)
//   flush, cf_*                pipeline flush and control-flow redirect of the PC
//   fwd_rd/fwd_wdata/fwd_late  forwarding sources, index 0 youngest
//   gpr_wen/gpr_rd/gpr_wdata   register-file write port
//   s3_*                       execute-side payload and handshake (s3_p_valid/s3_p_busy)
//   stall_cycles               saturating count of hazard stall cycles
module frv_dispatch_nfwd #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NFWD     = 2,
  parameter int unsigned     SKID     = 1,
  parameter logic [XLEN-1:0] PC_RESET = 32'h8000_0000
) (
  input  logic                 g_clk,
  input  logic                 g_resetn,
  input  logic                 s2_p_valid,
  output logic                 s2_p_busy,
  input  logic [4:0]           s2_rd,
  input  logic [4:0]           s2_rs1,
  input  logic [4:0]           s2_rs2,
  input  logic [XLEN-1:0]      s2_imm,
  input  logic [4:0]           s2_uop,
  input  logic [4:0]           s2_fu,
  input  logic                 s2_trap,
  input  logic [1:0]           s2_size,
  input  logic [31:0]          s2_instr,
  input  logic                 s2_wb,
  input  logic [7:0]           s2_opr_src,
  input  logic                 flush,
  input  logic                 cf_req,
  input  logic                 cf_ack,
  input  logic [XLEN-1:0]      cf_target,
  input  logic [5*NFWD-1:0]    fwd_rd,
  input  logic [XLEN*NFWD-1:0] fwd_wdata,
  input  logic [NFWD-1:0]      fwd_late,
  input  logic                 gpr_wen,
  input  logic [4:0]           gpr_rd,
  input  logic [XLEN-1:0]      gpr_wdata,
  output logic [4:0]           s3_rd,
  output logic [XLEN-1:0]      s3_pc,
  output logic [XLEN-1:0]      s3_opr_a,
  output logic [XLEN-1:0]      s3_opr_b,
  output logic [XLEN-1:0]      s3_opr_c,
  output logic [4:0]           s3_uop,
  output logic [4:0]           s3_fu,
  output logic                 s3_trap,
  output logic [1:0]           s3_size,
  output logic [31:0]          s3_instr,
  output logic                 s3_p_valid,
  input  logic                 s3_p_busy,
  output logic [31:0]          stall_cycles
);

  localparam int unsigned XL    = XLEN - 1;
  localparam int          Depth = (SKID != 0) ? 2 : 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [XL:0] pc;
    logic [XL:0] opr_a;
    logic [XL:0] opr_b;
    logic [XL:0] opr_c;
    logic [4:0]  uop;
    logic [4:0]  fu;
    logic        trap;
    logic [1:0]  size;
    logic [31:0] instr;
  } entry_t;

  logic [XL:0] gpr_q [0:31];
  logic [XL:0] pc_q, pc_d;
  logic [31:0] stall_q, stall_d;
  entry_t      ent_q [Depth];
  entry_t      ent_d [Depth];
  logic [1:0]  cnt_q, cnt_d;

  logic        hazard, buffer_full, accept, deq;
  logic [XL:0] rs1_val, rs2_val, pc_imm, pc_inc;
  logic [1:0]  wr_idx;
  entry_t      new_ent;

  // GPR file has no reset; x0 is never written.
  always_ff @(posedge g_clk) begin
    if (gpr_wen && gpr_rd != 5'd0) begin
      gpr_q[gpr_rd] <= gpr_wdata;
    end
  end

  // Operand fetch. Priority: youngest forwarding source, then a same-cycle GPR write,
  // then the stored GPR value. x0 always reads as zero.
  always_comb begin
    rs1_val = gpr_q[s2_rs1];
    rs2_val = gpr_q[s2_rs2];
    if (gpr_wen && gpr_rd == s2_rs1) rs1_val = gpr_wdata;
    if (gpr_wen && gpr_rd == s2_rs2) rs2_val = gpr_wdata;
    // Walk oldest to youngest so the lowest matching index wins.
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (fwd_rd[5*i +: 5] == s2_rs1) rs1_val = fwd_wdata[XLEN*i +: XLEN];
      if (fwd_rd[5*i +: 5] == s2_rs2) rs2_val = fwd_wdata[XLEN*i +: XLEN];
    end
    if (s2_rs1 == 5'd0) rs1_val = '0;
    if (s2_rs2 == 5'd0) rs2_val = '0;
  end

  // A late source (load/CSR) cannot be forwarded yet, so the instruction must wait.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < NFWD; i++) begin
      if (fwd_late[i] && fwd_rd[5*i +: 5] != 5'd0 &&
          (fwd_rd[5*i +: 5] == s2_rs1 || fwd_rd[5*i +: 5] == s2_rs2)) begin
        hazard = 1'b1;
      end
    end
  end

  assign deq         = s3_p_valid & ~s3_p_busy;
  assign buffer_full = (SKID != 0) ? (cnt_q == 2'd2) : (s3_p_valid & s3_p_busy);
  assign s2_p_busy   = hazard | buffer_full;
  assign accept      = s2_p_valid & ~s2_p_busy & ~flush;

  assign pc_imm = pc_q + s2_imm;
  assign pc_inc = s2_size[1] ? XLEN'(4) : (s2_size[0] ? XLEN'(2) : '0);

  // Operand selects are one-hot per operand, so an AND-OR mux suffices.
  always_comb begin
    new_ent       = '0;
    new_ent.rd    = (s2_wb | s2_trap) ? s2_rd : 5'd0;
    new_ent.pc    = pc_q;
    new_ent.opr_a = ({XLEN{s2_opr_src[0]}} & rs1_val)
                  | ({XLEN{s2_opr_src[1]}} & pc_imm)
                  | ({XLEN{s2_opr_src[2]}} & XLEN'(s2_rs1));
    new_ent.opr_b = ({XLEN{s2_opr_src[3]}} & rs2_val)
                  | ({XLEN{s2_opr_src[4]}} & s2_imm);
    new_ent.opr_c = ({XLEN{s2_opr_src[5]}} & rs2_val)
                  | ({XLEN{s2_opr_src[6]}} & XLEN'(s2_imm[31:20]))
                  | ({XLEN{s2_opr_src[7]}} & pc_imm);
    new_ent.uop   = s2_uop;
    new_ent.fu    = s2_fu;
    new_ent.trap  = s2_trap;
    new_ent.size  = s2_size;
    new_ent.instr = s2_instr;
  end

  // Redirect wins over sequential advance; flush leaves the PC alone.
  always_comb begin
    pc_d = pc_q;
    if (cf_req && cf_ack) begin
      pc_d = cf_target;
    end else if (accept) begin
      pc_d = pc_q + pc_inc;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (s2_p_valid && hazard && stall_q != 32'hFFFF_FFFF) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Slot 0 is always the head, so s3 outputs come straight from one register.
  // On dequeue the tail shifts forward, and a new entry lands in the first free slot.
  always_comb begin
    ent_d  = ent_q;
    cnt_d  = cnt_q;
    wr_idx = cnt_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      if (deq) begin
        for (int i = 0; i < Depth - 1; i++) begin
          ent_d[i] = ent_q[i+1];
        end
        wr_idx = cnt_q - 2'd1;
      end
      for (int i = 0; i < Depth; i++) begin
        if (accept && i == int'(wr_idx)) ent_d[i] = new_ent;
      end
      cnt_d = cnt_q + {1'b0, accept} - {1'b0, deq};
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      pc_q    <= PC_RESET;
      stall_q <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < Depth; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      pc_q    <= pc_d;
      stall_q <= stall_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < Depth; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

  assign s3_p_valid   = (cnt_q != 2'd0);
  assign s3_rd        = ent_q[0].rd;
  assign s3_pc        = ent_q[0].pc;
  assign s3_opr_a     = ent_q[0].opr_a;
  assign s3_opr_b     = ent_q[0].opr_b;
  assign s3_opr_c     = ent_q[0].opr_c;
  assign s3_uop       = ent_q[0].uop;
  assign s3_fu        = ent_q[0].fu;
  assign s3_trap      = ent_q[0].trap;
  assign s3_size      = ent_q[0].size;
  assign s3_instr     = ent_q[0].instr;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_frv_dispatch_nfwd.sv
// Testbench for frv_dispatch_nfwd. Stimulus issues directed instructions and pushes the
// hand-computed expected s3 payload. A separate monitor pops an expected payload and
// compares it each time the DUT hands an entry to execute.
module tb_frv_dispatch_nfwd;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        s2_p_valid, s2_p_busy;
  logic [4:0]  s2_rd, s2_rs1, s2_rs2, s2_uop, s2_fu;
  logic [31:0] s2_imm, s2_instr, cf_target, gpr_wdata;
  logic        s2_trap, s2_wb, flush, cf_req, cf_ack, gpr_wen;
  logic [1:0]  s2_size;
  logic [7:0]  s2_opr_src;
  logic [9:0]  fwd_rd;
  logic [63:0] fwd_wdata;
  logic [1:0]  fwd_late;
  logic [4:0]  gpr_rd;
  logic [4:0]  s3_rd, s3_uop, s3_fu;
  logic [31:0] s3_pc, s3_opr_a, s3_opr_b, s3_opr_c, s3_instr, stall_cycles;
  logic        s3_trap, s3_p_valid, s3_p_busy;
  logic [1:0]  s3_size;

  always #5 g_clk = ~g_clk;

  frv_dispatch_nfwd #(
    .XLEN(32), .NFWD(2), .SKID(1), .PC_RESET(32'h8000_0000)
  ) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .s2_p_valid(s2_p_valid), .s2_p_busy(s2_p_busy),
    .s2_rd(s2_rd), .s2_rs1(s2_rs1), .s2_rs2(s2_rs2), .s2_imm(s2_imm),
    .s2_uop(s2_uop), .s2_fu(s2_fu), .s2_trap(s2_trap), .s2_size(s2_size),
    .s2_instr(s2_instr), .s2_wb(s2_wb), .s2_opr_src(s2_opr_src),
    .flush(flush), .cf_req(cf_req), .cf_ack(cf_ack), .cf_target(cf_target),
    .fwd_rd(fwd_rd), .fwd_wdata(fwd_wdata), .fwd_late(fwd_late),
    .gpr_wen(gpr_wen), .gpr_rd(gpr_rd), .gpr_wdata(gpr_wdata),
    .s3_rd(s3_rd), .s3_pc(s3_pc), .s3_opr_a(s3_opr_a), .s3_opr_b(s3_opr_b),
    .s3_opr_c(s3_opr_c), .s3_uop(s3_uop), .s3_fu(s3_fu), .s3_trap(s3_trap),
    .s3_size(s3_size), .s3_instr(s3_instr),
    .s3_p_valid(s3_p_valid), .s3_p_busy(s3_p_busy),
    .stall_cycles(stall_cycles)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] pc, a, b, c;
    logic [4:0]  uop, fu;
    logic        trap;
    logic [1:0]  size;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic [4:0]  rd, rs1, rs2, uop, fu;
    logic [31:0] imm, instr;
    logic [7:0]  src;
    logic [1:0]  size;
    logic        wb, trap;
  } stim_t;

  exp_t  exp_q[$];
  exp_t  mon_got, mon_exp;
  int    n_checks = 0;
  int    n_fail = 0;
  stim_t st;

  function automatic stim_t mk(input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [31:0] imm,
                               input logic [7:0] src, input logic [1:0] size,
                               input logic wb, input logic trap, input logic [31:0] instr);
    stim_t s;
    s.rd = rd; s.rs1 = rs1; s.rs2 = rs2; s.imm = imm; s.src = src; s.size = size;
    s.wb = wb; s.trap = trap; s.instr = instr;
    s.uop = instr[4:0]; s.fu = instr[9:5];
    return s;
  endfunction

  function automatic exp_t ex(input logic [4:0] rd, input logic [31:0] pc,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input stim_t s);
    exp_t e;
    e.rd = rd; e.pc = pc; e.a = a; e.b = b; e.c = c;
    e.uop = s.uop; e.fu = s.fu; e.trap = s.trap; e.size = s.size; e.instr = s.instr;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic drive(input stim_t s);
    s2_rd = s.rd; s2_rs1 = s.rs1; s2_rs2 = s.rs2; s2_imm = s.imm; s2_uop = s.uop;
    s2_fu = s.fu; s2_trap = s.trap; s2_size = s.size; s2_instr = s.instr;
    s2_wb = s.wb; s2_opr_src = s.src;
  endtask

  // Entered and left at posedge+1; the expected entry is queued once the DUT can accept.
  task automatic issue(input string name, input stim_t s, input exp_t e);
    int n;
    drive(s);
    s2_p_valid = 1'b1;
    n = 0;
    @(negedge g_clk);
    while (s2_p_busy && n < 50) begin
      @(negedge g_clk);
      n++;
    end
    if (s2_p_busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: accept timeout, s2_p_busy got 1 want 0", name);
    end else begin
      exp_q.push_back(e);
    end
    @(posedge g_clk);
    #1;
    s2_p_valid = 1'b0;
  endtask

  // Monitor: a handoff to execute happens whenever valid is seen without busy.
  initial begin
    forever begin
      @(negedge g_clk);
      if (g_resetn && s3_p_valid && !s3_p_busy && !flush) begin
        mon_got = {s3_rd, s3_pc, s3_opr_a, s3_opr_b, s3_opr_c, s3_uop, s3_fu, s3_trap,
                   s3_size, s3_instr};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL s3_out: unexpected entry pc %h got, none required", s3_pc);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            n_fail++;
            $display("FAIL s3_out: got %h want %h", mon_got, mon_exp);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    s2_p_valid = 0; drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    flush = 0; cf_req = 0; cf_ack = 0; cf_target = 0;
    fwd_rd = 0; fwd_wdata = 0; fwd_late = 0;
    gpr_wen = 0; gpr_rd = 0; gpr_wdata = 0; s3_p_busy = 0;
    g_resetn = 0;
    repeat (3) @(posedge g_clk);
    #1;
    check("reset_s3_valid", 32'(s3_p_valid), 0);
    check("reset_stall", stall_cycles, 0);
    check("reset_s3_pc", s3_pc, 0);
    check("reset_s3_opr_a", s3_opr_a, 0);
    check("reset_s3_rd", 32'(s3_rd), 0);
    check("reset_s2_busy", 32'(s2_p_busy), 0);
    g_resetn = 1;

    // Sequential PC, 4-byte instructions
    st = mk(1, 0, 0, 0, 8'h00, 2'b10, 1, 0, 32'h0000_0013);
    issue("pc0", st, ex(1, 32'h8000_0000, 0, 0, 0, st));
    st = mk(1, 0, 0, 0, 8'h00, 2'b10, 1, 0, 32'h0000_0113);
    issue("pc1", st, ex(1, 32'h8000_0004, 0, 0, 0, st));
    st = mk(1, 0, 0, 0, 8'h00, 2'b10, 1, 0, 32'h0000_0213);
    issue("pc2", st, ex(1, 32'h8000_0008, 0, 0, 0, st));

    // Same-cycle GPR write bypass; no wb/trap zeroes rd
    gpr_wen = 1; gpr_rd = 3; gpr_wdata = 32'hDEAD_BEEF;
    st = mk(9, 3, 0, 0, 8'h01, 2'b10, 0, 0, 32'h0001_8093);
    issue("gpr_bypass", st, ex(0, 32'h8000_000C, 32'hDEAD_BEEF, 0, 0, st));
    gpr_wen = 0; gpr_wdata = 0;
    // Stored GPR read, trap keeps rd, 2-byte instruction
    st = mk(5, 3, 0, 0, 8'h09, 2'b01, 0, 1, 32'h0002_0113);
    issue("gpr_stored", st, ex(5, 32'h8000_0010, 32'hDEAD_BEEF, 0, 0, st));

    // Forwarding: lowest index wins, x0 never forwarded, size 0 holds PC
    fwd_rd = {5'd7, 5'd7}; fwd_wdata = {32'd22, 32'd11};
    st = mk(2, 0, 7, 0, 8'h28, 2'b00, 1, 0, 32'h0000_0300);
    issue("fwd_idx0", st, ex(2, 32'h8000_0012, 0, 11, 11, st));
    st = mk(2, 0, 0, 0, 8'h08, 2'b10, 1, 0, 32'h0000_0400);
    issue("fwd_x0", st, ex(2, 32'h8000_0012, 0, 0, 0, st));
    fwd_rd = {5'd7, 5'd8};
    st = mk(4, 7, 0, 0, 8'h01, 2'b10, 1, 0, 32'h0000_0500);
    issue("fwd_idx1", st, ex(4, 32'h8000_0016, 22, 0, 0, st));
    fwd_rd = 0; fwd_wdata = 0;

    // Remaining operand selects
    st = mk(6, 0, 0, 32'h0000_0100, 8'h92, 2'b10, 1, 0, 32'h0000_0600);
    issue("sel_pcimm", st, ex(6, 32'h8000_001A, 32'h8000_011A, 32'h100, 32'h8000_011A, st));
    st = mk(6, 17, 0, 32'hABC0_0000, 8'h44, 2'b10, 1, 0, 32'h0000_0700);
    issue("sel_rsidx_imm12", st, ex(6, 32'h8000_001E, 32'd17, 0, 32'hABC, st));

    // Late-result hazard stalls 3 cycles then releases
    fwd_rd = {5'd0, 5'd5}; fwd_wdata = {32'd0, 32'h55}; fwd_late = 2'b01;
    st = mk(8, 5, 0, 0, 8'h01, 2'b10, 1, 0, 32'h0000_0800);
    drive(st);
    s2_p_valid = 1;
    repeat (3) begin
      @(negedge g_clk);
      check("hazard_busy", 32'(s2_p_busy), 1);
      @(posedge g_clk);
      #1;
    end
    check("stall_cycles_3", stall_cycles, 3);
    fwd_late = 0;
    issue("hazard_release", st, ex(8, 32'h8000_0022, 32'h55, 0, 0, st));
    check("stall_hold", stall_cycles, 3);
    fwd_rd = {5'd6, 5'd0}; fwd_late = 2'b10; s2_rs1 = 0; s2_rs2 = 6;
    @(negedge g_clk);
    check("hazard_rs2_idx1", 32'(s2_p_busy), 1);
    fwd_rd = 0; fwd_late = 2'b11; s2_rs2 = 0;
    @(negedge g_clk);
    check("no_hazard_x0", 32'(s2_p_busy), 0);
    @(posedge g_clk);
    #1;
    fwd_late = 0;
    check("stall_needs_valid", stall_cycles, 3);

    // Skid buffer fills to two, then drains in order
    s3_p_busy = 1;
    st = mk(10, 0, 0, 0, 8'h00, 2'b10, 1, 0, 32'h0000_0A00);
    issue("skid0", st, ex(10, 32'h8000_0026, 0, 0, 0, st));
    st = mk(11, 0, 0, 0, 8'h00, 2'b10, 1, 0, 32'h0000_0B00);
    issue("skid1", st, ex(11, 32'h8000_002A, 0, 0, 0, st));
    @(negedge g_clk);
    check("skid_full_busy", 32'(s2_p_busy), 1);
    check("skid_valid", 32'(s3_p_valid), 1);
    @(posedge g_clk);
    #1;
    s3_p_busy = 0;
    repeat (3) @(posedge g_clk);
    #1;
    check("skid_drained", 32'(exp_q.size()), 0);

    // Control-flow redirect during accept; request without ack is ignored
    cf_req = 1; cf_ack = 1; cf_target = 32'h8000_0100;
    st = mk(12, 0, 0, 0, 8'h00, 2'b10, 1, 0, 32'h0000_0C00);
    issue("cf_accept", st, ex(12, 32'h8000_002E, 0, 0, 0, st));
    cf_ack = 0; cf_target = 32'h9000_0000;
    st = mk(13, 0, 0, 0, 8'h00, 2'b10, 1, 0, 32'h0000_0D00);
    issue("cf_target", st, ex(13, 32'h8000_0100, 0, 0, 0, st));
    cf_req = 0;

    // Flush with redirect and valid instruction: buffer emptied, nothing enqueued
    s3_p_busy = 1;
    st = mk(14, 0, 0, 0, 8'h00, 2'b10, 1, 0, 32'h0000_0E00);
    issue("pre_flush", st, ex(14, 32'h8000_0104, 0, 0, 0, st));
    drive(mk(15, 0, 0, 0, 8'h00, 2'b10, 1, 0, 32'h0000_0F00));
    s2_p_valid = 1; flush = 1; cf_req = 1; cf_ack = 1; cf_target = 32'h8000_0200;
    @(posedge g_clk);
    #1;
    flush = 0; s2_p_valid = 0; cf_req = 0; cf_ack = 0;
    exp_q.delete();
    check("flush_empties", 32'(s3_p_valid), 0);
    s3_p_busy = 0;
    st = mk(16, 0, 0, 0, 8'h00, 2'b10, 1, 0, 32'h0000_1000);
    issue("post_flush_cf", st, ex(16, 32'h8000_0200, 0, 0, 0, st));
    repeat (2) @(posedge g_clk);
    #1;
    // Flush alone must not move the PC
    drive(mk(17, 0, 0, 0, 8'h00, 2'b10, 1, 0, 32'h0000_1100));
    s2_p_valid = 1; flush = 1;
    @(posedge g_clk);
    #1;
    flush = 0; s2_p_valid = 0;
    st = mk(18, 0, 0, 0, 8'h00, 2'b10, 1, 0, 32'h0000_1200);
    issue("flush_keeps_pc", st, ex(18, 32'h8000_0204, 0, 0, 0, st));
    repeat (2) @(posedge g_clk);
    #1;

    // Reset beats accept and redirect
    g_resetn = 0;
    drive(mk(19, 0, 0, 0, 8'h00, 2'b10, 1, 0, 32'h0000_1300));
    s2_p_valid = 1; cf_req = 1; cf_ack = 1; cf_target = 32'h0000_1234;
    @(posedge g_clk);
    #1;
    g_resetn = 1; s2_p_valid = 0; cf_req = 0; cf_ack = 0;
    check("rst_prio_valid", 32'(s3_p_valid), 0);
    check("rst_prio_stall", stall_cycles, 0);
    check("rst_prio_s3_pc", s3_pc, 0);
    st = mk(20, 0, 0, 0, 8'h00, 2'b10, 1, 0, 32'h0000_1400);
    issue("rst_prio_pc", st, ex(20, 32'h8000_0000, 0, 0, 0, st));
    repeat (3) @(posedge g_clk);
    #1;
    check("final_queue_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
